// File: rtl/si_frame_decoder.sv
// rtl/si_frame_decoder.sv - assembles received bytes into {address, data} simple-interface register writes
// Inter-byte timeout drops partial frames so a desynchronised host recovers.
module si_frame_decoder #(
  parameter int REG_ADDR_WIDTH = 8,
  parameter int REG_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                rx_data,
  input  logic                      rx_rdy,
  output logic [REG_ADDR_WIDTH-1:0] si_addr,
  output logic [REG_DATA_WIDTH-1:0] si_data,
  output logic                      si_rdy,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int AB = REG_ADDR_WIDTH / 8;
  localparam int DB = REG_DATA_WIDTH / 8;
  localparam int FB = AB + DB;
  localparam int CW = $clog2(FB + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CW-1:0] LAST_A = CW'(AB - 1);
  localparam logic [CW-1:0] LAST_D = CW'(FB - 1);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] S_ADDR = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  logic [1:0]                state;
  logic [CW-1:0]             cnt;
  logic [TW-1:0]             tcnt;
  logic [REG_ADDR_WIDTH-1:0] addr_sr;
  logic [REG_DATA_WIDTH-1:0] data_sr;
  logic [REG_ADDR_WIDTH-1:0] next_addr;
  logic [REG_DATA_WIDTH-1:0] next_data;

  assign next_addr = (addr_sr << 8) | REG_ADDR_WIDTH'(rx_data);
  assign next_data = (data_sr << 8) | REG_DATA_WIDTH'(rx_data);
  assign busy_o    = (cnt != '0) || (state == S_DATA);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_ADDR;
      cnt       <= '0;
      tcnt      <= '0;
      addr_sr   <= '0;
      data_sr   <= '0;
      si_addr   <= '0;
      si_data   <= '0;
      si_rdy    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      si_rdy    <= 1'b0;
      timeout_o <= 1'b0;
      if (rx_rdy) begin
        // An accepted byte always beats a coincident timeout.
        tcnt <= '0;
        if (state == S_DATA) begin
          data_sr <= next_data;
          if (cnt == LAST_D) begin
            state   <= S_EMIT;
            cnt     <= '0;
            si_addr <= addr_sr;
            si_data <= next_data;
            si_rdy  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          // S_EMIT falls through here: the byte opens the next frame.
          addr_sr <= next_addr;
          cnt     <= cnt + 1'b1;
          state   <= (cnt == LAST_A) ? S_DATA : S_ADDR;
        end
      end else begin
        if (state == S_EMIT) state <= S_ADDR;
        if (!busy_o) begin
          tcnt <= '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (tcnt == T_LAST) begin
            state     <= S_ADDR;
            cnt       <= '0;
            tcnt      <= '0;
            timeout_o <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
